// File: rtl/id_exe_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_exe_pipe_reg
//   ID->EXE pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer (head M, skid S). in_ready_o is derived only from registered state,
//   so an EXE-side stall never reaches decode combinationally. Entries leave in
//   acceptance order. A synchronous flush (branch redirect) kills everything
//   held, including a same-cycle accept.
//
//   Optional feature macro: ID_EXE_WB_SNOOP_EN
//     When defined, the wb_we_i / wb_addr_i / wb_data_i ports exist. Every
//     cycle, rs1/rs2 data of the held entries and of the entry being accepted
//     is replaced by wb_data_i when the writeback hits a matching non-zero
//     register address.
//
// Ports
//   clk_i_id_exe_pipe   rising-edge clock
//   rst_i_id_exe_pipe   asynchronous active-low reset
//   flush_i             synchronous kill of all held entries
//   in_valid_i/in_ready_o    decode-side handshake
//   in_*_i              decode-side payload
//   out_valid_o/out_ready_i  EXE-side handshake
//   out_*_o             head entry payload; out_regWrite_o gated by out_valid_o
//   wb_we_i/wb_addr_i/wb_data_i  writeback snoop port (feature only)
// ----------------------------------------------------------------------------
module id_exe_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 4,
    parameter int IMM_W   = 32,
    parameter int PC_W    = 32
) (
    input  logic               clk_i_id_exe_pipe,
    input  logic               rst_i_id_exe_pipe,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    in_pc_i,
    input  logic               in_regWrite_i,
    input  logic [ALUOP_W-1:0] in_ALUOp_i,
    input  logic [IMM_W-1:0]   in_imm_i,
    input  logic [ADDR_W-1:0]  in_rs1_addr_i,
    input  logic [ADDR_W-1:0]  in_rs2_addr_i,
    input  logic [ADDR_W-1:0]  in_rd_addr_i,
    input  logic [DATA_W-1:0]  in_rs1_data_i,
    input  logic [DATA_W-1:0]  in_rs2_data_i,
`ifdef ID_EXE_WB_SNOOP_EN
    input  logic               wb_we_i,
    input  logic [ADDR_W-1:0]  wb_addr_i,
    input  logic [DATA_W-1:0]  wb_data_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    out_pc_o,
    output logic               out_regWrite_o,
    output logic [ALUOP_W-1:0] out_ALUOp_o,
    output logic [IMM_W-1:0]   out_imm_o,
    output logic [ADDR_W-1:0]  out_rs1_addr_o,
    output logic [ADDR_W-1:0]  out_rs2_addr_o,
    output logic [ADDR_W-1:0]  out_rd_addr_o,
    output logic [DATA_W-1:0]  out_rs1_data_o,
    output logic [DATA_W-1:0]  out_rs2_data_o
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic               regwrite;
        logic [ALUOP_W-1:0] aluop;
        logic [IMM_W-1:0]   imm;
        logic [ADDR_W-1:0]  rs1_addr;
        logic [ADDR_W-1:0]  rs2_addr;
        logic [ADDR_W-1:0]  rd_addr;
        logic [DATA_W-1:0]  rs1_data;
        logic [DATA_W-1:0]  rs2_data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // EMPTY: nothing held; ONE: M valid; TWO: M and S valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t in_entry_s;
    entry_t in_eff_s;
    entry_t m_eff_s;
    entry_t s_eff_s;
    logic   accept_s;
    logic   issue_s;

    assign in_entry_s.pc       = in_pc_i;
    assign in_entry_s.regwrite = in_regWrite_i;
    assign in_entry_s.aluop    = in_ALUOp_i;
    assign in_entry_s.imm      = in_imm_i;
    assign in_entry_s.rs1_addr = in_rs1_addr_i;
    assign in_entry_s.rs2_addr = in_rs2_addr_i;
    assign in_entry_s.rd_addr  = in_rd_addr_i;
    assign in_entry_s.rs1_data = in_rs1_data_i;
    assign in_entry_s.rs2_data = in_rs2_data_i;

`ifdef ID_EXE_WB_SNOOP_EN
    // Replace rs1/rs2 data of one entry on a writeback hit; x0 never matches.
    function automatic entry_t snoop_entry(input entry_t e,
                                           input logic we,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] data);
        entry_t r;
        r = e;
        if (we && (addr != {ADDR_W{1'b0}}) && (addr == e.rs1_addr)) begin
            r.rs1_data = data;
        end else begin
            r.rs1_data = e.rs1_data;
        end
        if (we && (addr != {ADDR_W{1'b0}}) && (addr == e.rs2_addr)) begin
            r.rs2_data = data;
        end else begin
            r.rs2_data = e.rs2_data;
        end
        return r;
    endfunction

    assign in_eff_s = snoop_entry(in_entry_s, wb_we_i, wb_addr_i, wb_data_i);
    assign m_eff_s  = snoop_entry(m_q,        wb_we_i, wb_addr_i, wb_data_i);
    assign s_eff_s  = snoop_entry(s_q,        wb_we_i, wb_addr_i, wb_data_i);
`else
    assign in_eff_s = in_entry_s;
    assign m_eff_s  = m_q;
    assign s_eff_s  = s_q;
`endif

    // Ready depends only on the registered state so stalls do not chain back.
    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept_s    = in_valid_i & in_ready_o;
    assign issue_s     = out_valid_o & out_ready_i;

    // Next-state and next-payload selection for the two-entry skid buffer.
    always_comb begin
        state_d = state_q;
        m_d     = m_eff_s;
        s_d     = s_eff_s;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        m_d     = in_eff_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && issue_s) begin
                        m_d     = in_eff_s;
                        state_d = ST_ONE;
                    end else if (accept_s) begin
                        s_d     = in_eff_s;
                        state_d = ST_TWO;
                    end else if (issue_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // Skid entry becomes the head; S is freed via the state.
                    if (issue_s) begin
                        m_d     = s_eff_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_i_id_exe_pipe or negedge rst_i_id_exe_pipe) begin
        if (!rst_i_id_exe_pipe) begin
            state_q <= ST_EMPTY;
            m_q     <= entry_t'({ENTRY_W{1'b0}});
            s_q     <= entry_t'({ENTRY_W{1'b0}});
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign out_pc_o       = m_q.pc;
    assign out_regWrite_o = m_q.regwrite & out_valid_o;
    assign out_ALUOp_o    = m_q.aluop;
    assign out_imm_o      = m_q.imm;
    assign out_rs1_addr_o = m_q.rs1_addr;
    assign out_rs2_addr_o = m_q.rs2_addr;
    assign out_rd_addr_o  = m_q.rd_addr;
    assign out_rs1_data_o = m_q.rs1_data;
    assign out_rs2_data_o = m_q.rs2_data;

endmodule
